// File: rtl/timer_scheduler.sv
// Round-robin shared down-counter: one owner at a time, done pulse at zero.
// Optional abort input enabled by defining TIMER_SCHED_ABORT_EN.
module timer_scheduler #(
  parameter int NREQ     = 4,
  parameter int BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BITWIDTH-1:0] load_val,
`ifdef TIMER_SCHED_ABORT_EN
  input  logic                     abort,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [BITWIDTH-1:0]      cnt,
  output logic [NREQ-1:0]          done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       w_ptr_nxt;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       w_owner_nxt;
  logic [IW-1:0]       w_owner_inc;
  logic [IW-1:0]       w_win;
  logic [IW:0]         w_j;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     w_gnt_nxt;
  logic [NREQ-1:0]     r_done;
  logic [NREQ-1:0]     w_done_nxt;
  logic [BITWIDTH-1:0] r_cnt;
  logic [BITWIDTH-1:0] w_cnt_nxt;
  logic                r_busy;
  logic                w_abort;
  logic [BITWIDTH-1:0] w_lv [NREQ];

`ifdef TIMER_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_lv
    assign w_lv[g] = load_val[g*BITWIDTH +: BITWIDTH];
  end

  // Descending scan so the requester closest to r_ptr is assigned last.
  always_comb begin
    w_win = r_ptr;
    w_j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_j >= (IW+1)'(NREQ)) begin
        w_j = w_j - (IW+1)'(NREQ);
      end
      if (req[w_j[IW-1:0]]) begin
        w_win = w_j[IW-1:0];
      end
    end
  end

  assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0
                     : r_owner + IW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_win;
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_cnt_nxt   = w_lv[w_win];
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_abort) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_done_nxt  = r_gnt;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - BITWIDTH'(1);
        end
      end
      S_DONE: begin
        w_gnt_nxt   = '0;
        w_ptr_nxt   = w_owner_inc;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cnt   <= '1;
      r_ptr   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign cnt  = r_cnt;
  assign busy = r_busy;

endmodule
